// File: rtl/palette_ram_banked.sv
`default_nettype none
// ============================================================================
// Module      : palette_ram_banked
// Description : Writable multi-bank NES palette memory. Holds NBANK sets of
//               32 colour entries and fills every entry with INIT_VAL after
//               reset. Provides a CPU-side write/read port with $3F00-style
//               mirroring and a pipelined pixel lookup port with backdrop
//               substitution.
// Ports       : clk, rst_n        - clock, async active-low reset
//               busy              - post-reset clear in progress
//               wr_en/wr_rdy      - write request / write accepted
//               wr_bank/addr/data - write target and data (address mirrored)
//               rd_en/bank/addr   - CPU read request (address mirrored)
//               rd_data/rd_valid  - CPU read result, 1-cycle latency
//               pix_en/bank/idx   - pixel lookup (idx[1:0]==0 -> backdrop)
//               pix_color/valid   - pixel result, 1-cycle latency
// Revision    : 1.0 - initial release
// ============================================================================
module palette_ram_banked #(
  parameter int              NBANK    = 1,
  parameter int              DW       = 6,
  parameter logic [DW-1:0]   INIT_VAL = 6'h0F,
  localparam int             BW       = (NBANK > 1) ? $clog2(NBANK) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          busy,
  input  logic          wr_en,
  output logic          wr_rdy,
  input  logic [BW-1:0] wr_bank,
  input  logic [4:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [BW-1:0] rd_bank,
  input  logic [4:0]    rd_addr,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          pix_en,
  input  logic [BW-1:0] pix_bank,
  input  logic [4:0]    pix_idx,
  output logic [DW-1:0] pix_color,
  output logic          pix_valid
);

  localparam int DEPTH = NBANK * 32;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_clr_cnt;
  logic            w_clr_last;

  logic [DW-1:0]   r_mem [DEPTH];

  logic [4:0]      w_wr_eff;
  logic [4:0]      w_rd_eff;
  logic [4:0]      w_pix_eff;
  logic [AW-1:0]   w_wr_idx;
  logic [AW-1:0]   w_rd_idx;
  logic [AW-1:0]   w_pix_idx;

  logic            w_mem_we;
  logic [AW-1:0]   w_mem_waddr;
  logic [DW-1:0]   w_mem_wdata;

  // Sprite entries x0/x4/x8/xC alias the background entries below them.
  function automatic logic [4:0] cpu_mirror(input logic [4:0] a);
    return (a[4] && (a[1:0] == 2'b00)) ? {1'b0, a[3:0]} : a;
  endfunction

  assign w_wr_eff  = cpu_mirror(wr_addr);
  assign w_rd_eff  = cpu_mirror(rd_addr);
  // Any transparent colour slot shows the universal backdrop at entry 0.
  assign w_pix_eff = (pix_idx[1:0] == 2'b00) ? 5'd0 : pix_idx;

  // Bank select is exactly log2(NBANK) bits wide, so larger bank numbers
  // cannot be expressed and the modulo wrap is implicit.
  generate
    if (NBANK > 1) begin : g_multi_bank
      assign w_wr_idx  = {wr_bank,  w_wr_eff};
      assign w_rd_idx  = {rd_bank,  w_rd_eff};
      assign w_pix_idx = {pix_bank, w_pix_eff};
    end else begin : g_single_bank
      logic [3*BW-1:0] w_unused_banks;
      assign w_unused_banks = {wr_bank, rd_bank, pix_bank};
      assign w_wr_idx  = w_wr_eff;
      assign w_rd_idx  = w_rd_eff;
      assign w_pix_idx = w_pix_eff;
    end
  endgenerate

  assign w_clr_last = (r_clr_cnt == AW'(DEPTH - 1));

  // State register and clear counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) begin
        r_clr_cnt <= r_clr_cnt + AW'(1);
      end
    end
  end

  // Next-state and status outputs
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    wr_rdy      = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        busy = 1'b1;
        if (w_clr_last) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        wr_rdy = 1'b1;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  // The clear sequence owns the write port until it finishes; CPU writes
  // presented meanwhile are dropped.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_waddr = w_wr_idx;
    w_mem_wdata = wr_data;
    if (r_state == ST_CLEAR) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_clr_cnt;
      w_mem_wdata = INIT_VAL;
    end else if (wr_en) begin
      w_mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Read ports sample the array before this edge's write lands, giving
  // old-data behaviour on a same-entry collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      pix_color <= '0;
      pix_valid <= 1'b0;
    end else begin
      rd_valid  <= rd_en;
      pix_valid <= pix_en;
      if (rd_en) begin
        rd_data <= r_mem[w_rd_idx];
      end
      if (pix_en) begin
        pix_color <= r_mem[w_pix_idx];
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/palette_ram_banked.md
# palette_ram_banked

Writable, multi-bank NES palette memory: the parametrised successor to the fixed per-game palette ROMs. It holds NBANK sets of 32 colour entries, clears itself after reset, accepts CPU-side writes and reads with PPU $3F00 mirroring, and serves a pipelined pixel lookup port with backdrop substitution. It sits between the PPU pixel mux and the NES-colour-to-RGB converter, with the register interface on the write/read side.

## Interface
- NBANK, 1: number of 32-entry palette sets (power of two, 1..8).
- DW, 6: colour entry width (NES colour index).
- INIT_VAL, 6'h0F: value written to every entry by the post-reset clear.
- BW (derived), max(1, clog2(NBANK)): bank select width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- busy  out  1  clear sequence in progress.
- wr_en  in  1  write request.
- wr_rdy  out  1  write accepted this cycle when wr_en=1.
- wr_bank  in  BW  write bank.
- wr_addr  in  5  write entry address, mirrored.
- wr_data  in  DW  write data.
- rd_en  in  1  CPU read request.
- rd_bank  in  BW  read bank.
- rd_addr  in  5  read address, mirrored.
- rd_data  out  DW  read data.
- rd_valid  out  1  rd_data valid.
- pix_en  in  1  pixel lookup request.
- pix_bank  in  BW  pixel bank.
- pix_idx  in  5  {sprite/bg, palette[1:0], colour[1:0]}.
- pix_color  out  DW  looked-up colour.
- pix_valid  out  1  pix_color valid.

## Operation
- Mirroring, write and CPU read: if addr[4]=1 and addr[1:0]=0, the effective address is {0, addr[3:0]}. Examples: 0x10->0x00, 0x14->0x04, 0x18->0x08, 0x1C->0x0C. Other addresses are unchanged.
- Pixel backdrop: if pix_idx[1:0]=0, the effective address is 0x00 of pix_bank; otherwise pix_idx is used unmirrored.
- Storage: NBANK*32 entries, indexed {bank, eff_addr}. Bank values >= NBANK wrap modulo NBANK.
- State machine: CLEAR -> RUN.
  - CLEAR is entered on reset. A counter walks 0..NBANK*32-1 and writes INIT_VAL, one entry per cycle.
  - After the last entry the FSM goes to RUN. RUN has no exit except reset.
- CLEAR:
  - busy=1 and wr_rdy=0; wr_en is ignored and not queued.
  - rd_en and pix_en are still serviced; they return the current array contents.
- RUN:
  - busy=0 and wr_rdy=1; a write occurs on any cycle with wr_en=1.
- Ports are independent. A write, a CPU read and a pixel read may all occur in the same cycle.
- Read-during-write to the same effective entry: both read ports return the OLD value. The new value is visible from the next cycle's request.
- Data bits above DW do not exist; wr_data is stored as-is.

## Timing
- Reset (rst_n=0, async): busy=1, clear counter=0, rd_data=0, rd_valid=0, pix_color=0, pix_valid=0.
- Array contents are not reset directly; the clear sequence overwrites them.
- Clear length: the first clear write occurs on the first rising edge after rst_n deasserts. busy falls after exactly NBANK*32 edges, so wr_rdy is high on edge NBANK*32+1.
- Reset asserted mid-clear or mid-run: all outputs return immediately to reset values and the clear restarts from entry 0.
- CPU read: 1-cycle latency. A request at edge N gives rd_data and rd_valid=1 after edge N+1. rd_valid=0 when there is no request; rd_data holds its last value.
- Pixel: 1-cycle latency, fully pipelined, one lookup per cycle. pix_valid follows pix_en delayed by one cycle; pix_color holds when pix_en=0.
- Write: takes effect at the edge where wr_en & wr_rdy; no output response.

## Test plan
- Reset clear, NBANK=2:
  - release rst_n -> busy high for exactly 64 cycles.
  - then read every address of both banks -> 0x0F with rd_valid one cycle after each request.
- Mirroring, RUN:
  - write 0x10 <- 0x27 -> read 0x00 = 0x27.
  - write 0x0C <- 0x16 -> read 0x1C = 0x16.
  - write 0x11 <- 0x21 -> read 0x01 unchanged (0x0F).
- Backdrop:
  - write 0x00 <- 0x20, 0x06 <- 0x11 -> pix_idx 0x04, 0x18, 0x00 each give 0x20.
  - pix_idx 0x06 gives 0x11.
  - back-to-back pix_en gives one result per cycle.
- Banks: write bank1 0x05 <- 0x33 -> pix_bank=1 idx 0x05 gives 0x33; pix_bank=0 idx 0x05 gives 0x0F.
- Collision: same-cycle write 0x07 <- 0x12 with pix and rd to 0x07 -> both return the old 0x0F; the next-cycle request returns 0x12.
- Mid-clear:
  - wr_en during busy -> wr_rdy=0 and the entry stays 0x0F.
  - pulse rst_n low at clear cycle 20 -> outputs zero immediately; busy lasts a full NBANK*32 cycles after re-release.
